// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-stage load/store controller.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BEAT_LO,
        BEAT_HI,
        RESP
    } mem_state_t;

    localparam int BUS_W_DEFAULT  = 32;
    localparam int ALIGN_BITS     = 3;
    localparam int HI_WORD_OFFSET = 4;

endpackage

// File: rtl/beat_timer.sv
// Per-beat ack wait counter; clears on beat entry and counts cycles without ack.
module beat_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + CW'(1);
        end
    end

    // High in the no-ack cycle whose increment brings the count to TIMEOUT.
    assign expired = en && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store controller: one 64-bit access as two 32-bit bus beats.
//   state   | meaning
//   IDLE    | ready for a request
//   BEAT_LO | low word beat at addr
//   BEAT_HI | high word beat at addr+4
//   RESP    | one-cycle response pulse
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int N       = 64,
    parameter int BUS_W   = BUS_W_DEFAULT,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             memRead_M,
    input  logic             memWrite_M,
    input  logic [N-1:0]     addr_M,
    input  logic [N-1:0]     writeData_M,
    output logic             resp_valid,
    output logic             resp_err,
    output logic [N-1:0]     readData_M,
    output logic             bus_req,
    output logic             bus_we,
    output logic [N-1:0]     bus_addr,
    output logic [BUS_W-1:0] bus_wdata,
    input  logic             bus_ack,
    input  logic [BUS_W-1:0] bus_rdata
);

    mem_state_t       state;
    logic             is_load;
    logic [BUS_W-1:0] wdata_hi;
    logic [BUS_W-1:0] rdata_lo;
    logic             in_beat;
    logic             timer_clear;
    logic             timer_en;
    logic             timer_expired;

    assign req_ready   = (state == IDLE);
    assign in_beat     = (state == BEAT_LO) || (state == BEAT_HI);
    assign timer_clear = (state == IDLE) || ((state == BEAT_LO) && bus_ack);
    assign timer_en    = in_beat && !bus_ack;

    beat_timer #(.TIMEOUT(TIMEOUT)) u_beat_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .en      (timer_en),
        .expired (timer_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            is_load    <= 1'b0;
            wdata_hi   <= '0;
            rdata_lo   <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            readData_M <= '0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        is_load <= memRead_M && !memWrite_M;
                        if ((addr_M[ALIGN_BITS-1:0] != '0) || (memRead_M == memWrite_M)) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            if (memRead_M && !memWrite_M) readData_M <= '0;
                        end else begin
                            state     <= BEAT_LO;
                            bus_req   <= 1'b1;
                            bus_we    <= memWrite_M;
                            bus_addr  <= addr_M;
                            bus_wdata <= writeData_M[BUS_W-1:0];
                            wdata_hi  <= writeData_M[N-1:BUS_W];
                        end
                    end
                end
                BEAT_LO: begin
                    if (bus_ack) begin
                        state     <= BEAT_HI;
                        rdata_lo  <= bus_rdata;
                        bus_addr  <= bus_addr + N'(HI_WORD_OFFSET);
                        bus_wdata <= wdata_hi;
                    end else if (timer_expired) begin
                        state      <= RESP;
                        bus_req    <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        if (is_load) readData_M <= '0;
                    end
                end
                BEAT_HI: begin
                    if (bus_ack) begin
                        state      <= RESP;
                        bus_req    <= 1'b0;
                        resp_valid <= 1'b1;
                        if (is_load) readData_M <= {bus_rdata, rdata_lo};
                    end else if (timer_expired) begin
                        state      <= RESP;
                        bus_req    <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        if (is_load) readData_M <= '0;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    bus_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit.
module tb_mem_access_unit;

    localparam int N       = 64;
    localparam int BUS_W   = 32;
    localparam int TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             req_valid = 1'b0;
    logic             memRead_M = 1'b0;
    logic             memWrite_M = 1'b0;
    logic [N-1:0]     addr_M = '0;
    logic [N-1:0]     writeData_M = '0;
    logic             bus_ack = 1'b0;
    logic [BUS_W-1:0] bus_rdata = '0;
    logic             req_ready, resp_valid, resp_err, bus_req, bus_we;
    logic [N-1:0]     readData_M, bus_addr;
    logic [BUS_W-1:0] bus_wdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.N(N), .BUS_W(BUS_W), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .memRead_M   (memRead_M),
        .memWrite_M  (memWrite_M),
        .addr_M      (addr_M),
        .writeData_M (writeData_M),
        .resp_valid  (resp_valid),
        .resp_err    (resp_err),
        .readData_M  (readData_M),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_ack     (bus_ack),
        .bus_rdata   (bus_rdata)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Presents a request for exactly one edge; returns 1 ns into cycle 1.
    task automatic issue(input logic rd, input logic wr, input logic [N-1:0] a, input logic [N-1:0] d);
        memRead_M = rd; memWrite_M = wr; addr_M = a; writeData_M = d; req_valid = 1'b1;
        tick;
        req_valid = 1'b0; memRead_M = 1'b0; memWrite_M = 1'b0; addr_M = '0; writeData_M = '0;
    endtask

    task automatic test_reset;
        #1 reset = 1'b0;
        #2;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0 || bus_req !== 1'b0 || bus_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ready=%b rv=%b re=%b req=%b we=%b, expected 1 0 0 0 0", req_ready, resp_valid, resp_err, bus_req, bus_we);
        end
        checks++;
        if (readData_M !== 64'h0 || bus_addr !== 64'h0 || bus_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: rd=%h addr=%h wd=%h, expected zeros", readData_M, bus_addr, bus_wdata);
        end
        tick;
        tick;
        reset = 1'b1;
        tick;
        checks++;
        if (req_ready !== 1'b1 || bus_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%b req=%b, expected 1 0", req_ready, bus_req);
        end
    endtask

    task automatic test_load_zero_wait;
        issue(1'b1, 1'b0, 64'h100, '0);
        bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
        checks++;
        if (bus_req !== 1'b1 || bus_addr !== 64'h100 || bus_we !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL load_lo: req=%b addr=%h we=%b ready=%b, expected 1 100 0 0", bus_req, bus_addr, bus_we, req_ready);
        end
        tick;
        bus_rdata = 32'h01234567;
        checks++;
        if (bus_req !== 1'b1 || bus_addr !== 64'h104) begin
            errors++;
            $display("FAIL load_hi: req=%b addr=%h, expected 1 104", bus_req, bus_addr);
        end
        tick;
        bus_ack = 1'b0;
        checks++;
        if (resp_valid !== 1'b1 || resp_err !== 1'b0 || bus_req !== 1'b0) begin
            errors++;
            $display("FAIL load_resp: rv=%b re=%b req=%b, expected 1 0 0", resp_valid, resp_err, bus_req);
        end
        checks++;
        if (readData_M !== 64'h01234567DEADBEEF) begin
            errors++;
            $display("FAIL load_data: got %h expected 01234567deadbeef", readData_M);
        end
        tick;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL load_done: ready=%b rv=%b, expected 1 0", req_ready, resp_valid);
        end
    endtask

    task automatic test_store_wait;
        issue(1'b0, 1'b1, 64'h40, 64'hAAAA5555_11112222);
        for (int c = 1; c <= 4; c++) begin
            bus_ack = (c == 4);
            checks++;
            if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_addr !== 64'h40 || bus_wdata !== 32'h11112222 || resp_valid !== 1'b0) begin
                errors++;
                $display("FAIL store_lo c%0d: req=%b we=%b addr=%h wd=%h rv=%b, expected 1 1 40 11112222 0", c, bus_req, bus_we, bus_addr, bus_wdata, resp_valid);
            end
            tick;
        end
        bus_ack = 1'b1;
        checks++;
        if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_addr !== 64'h44 || bus_wdata !== 32'hAAAA5555) begin
            errors++;
            $display("FAIL store_hi: req=%b we=%b addr=%h wd=%h, expected 1 1 44 aaaa5555", bus_req, bus_we, bus_addr, bus_wdata);
        end
        tick;
        bus_ack = 1'b0;
        checks++;
        if (resp_valid !== 1'b1 || resp_err !== 1'b0 || readData_M !== 64'h01234567DEADBEEF) begin
            errors++;
            $display("FAIL store_resp: rv=%b re=%b rd=%h, expected 1 0 01234567deadbeef", resp_valid, resp_err, readData_M);
        end
        tick;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL store_single_pulse: rv=%b ready=%b, expected 0 1", resp_valid, req_ready);
        end
    endtask

    task automatic test_accept_errors;
        issue(1'b1, 1'b0, 64'h103, '0);
        checks++;
        if (bus_req !== 1'b0 || resp_valid !== 1'b1 || resp_err !== 1'b1 || readData_M !== 64'h0) begin
            errors++;
            $display("FAIL misaligned: req=%b rv=%b re=%b rd=%h, expected 0 1 1 0", bus_req, resp_valid, resp_err, readData_M);
        end
        tick;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || bus_req !== 1'b0) begin
            errors++;
            $display("FAIL misaligned_done: ready=%b rv=%b req=%b, expected 1 0 0", req_ready, resp_valid, bus_req);
        end
        issue(1'b1, 1'b1, 64'h108, '0);
        checks++;
        if (bus_req !== 1'b0 || resp_valid !== 1'b1 || resp_err !== 1'b1) begin
            errors++;
            $display("FAIL both_ops: req=%b rv=%b re=%b, expected 0 1 1", bus_req, resp_valid, resp_err);
        end
        tick;
        issue(1'b0, 1'b0, 64'h110, '0);
        checks++;
        if (bus_req !== 1'b0 || resp_valid !== 1'b1 || resp_err !== 1'b1) begin
            errors++;
            $display("FAIL no_op: req=%b rv=%b re=%b, expected 0 1 1", bus_req, resp_valid, resp_err);
        end
        tick;
    endtask

    task automatic test_ack_at_limit;
        issue(1'b1, 1'b0, 64'h200, '0);
        bus_rdata = 32'hCAFEF00D;
        for (int c = 1; c <= TIMEOUT; c++) begin
            bus_ack = (c == TIMEOUT);
            checks++;
            if (bus_req !== 1'b1 || bus_addr !== 64'h200 || resp_valid !== 1'b0) begin
                errors++;
                $display("FAIL limit_lo c%0d: req=%b addr=%h rv=%b, expected 1 200 0", c, bus_req, bus_addr, resp_valid);
            end
            tick;
        end
        bus_ack = 1'b1; bus_rdata = 32'h89ABCDEF;
        checks++;
        if (bus_req !== 1'b1 || bus_addr !== 64'h204) begin
            errors++;
            $display("FAIL limit_hi: req=%b addr=%h, expected 1 204", bus_req, bus_addr);
        end
        tick;
        bus_ack = 1'b0;
        checks++;
        if (resp_valid !== 1'b1 || resp_err !== 1'b0 || readData_M !== 64'h89ABCDEF_CAFEF00D) begin
            errors++;
            $display("FAIL limit_resp: rv=%b re=%b rd=%h, expected 1 0 89abcdefcafef00d", resp_valid, resp_err, readData_M);
        end
        tick;
    endtask

    task automatic test_timeout_hi;
        issue(1'b1, 1'b0, 64'h280, '0);
        bus_ack = 1'b1; bus_rdata = 32'h12345678;
        tick;
        bus_ack = 1'b0;
        for (int c = 1; c <= TIMEOUT; c++) begin
            checks++;
            if (bus_req !== 1'b1 || bus_addr !== 64'h284 || resp_valid !== 1'b0) begin
                errors++;
                $display("FAIL timeout_wait c%0d: req=%b addr=%h rv=%b, expected 1 284 0", c, bus_req, bus_addr, resp_valid);
            end
            tick;
        end
        checks++;
        if (bus_req !== 1'b0 || resp_valid !== 1'b1 || resp_err !== 1'b1 || readData_M !== 64'h0) begin
            errors++;
            $display("FAIL timeout_resp: req=%b rv=%b re=%b rd=%h, expected 0 1 1 0", bus_req, resp_valid, resp_err, readData_M);
        end
        tick;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_done: ready=%b rv=%b, expected 1 0", req_ready, resp_valid);
        end
    endtask

    task automatic test_reset_mid;
        issue(1'b1, 1'b0, 64'h300, '0);
        bus_ack = 1'b0;
        #2 reset = 1'b0;
        #1;
        checks++;
        if (bus_req !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_async: req=%b ready=%b, expected 0 1", bus_req, req_ready);
        end
        tick;
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (resp_valid !== 1'b0 || bus_req !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_quiet c%0d: rv=%b req=%b, expected 0 0", c, resp_valid, bus_req);
            end
            tick;
        end
        issue(1'b1, 1'b0, 64'h308, '0);
        bus_ack = 1'b1; bus_rdata = 32'h11111111;
        tick;
        bus_rdata = 32'h22222222;
        tick;
        bus_ack = 1'b0;
        checks++;
        if (resp_valid !== 1'b1 || resp_err !== 1'b0 || readData_M !== 64'h22222222_11111111) begin
            errors++;
            $display("FAIL reset_mid_next: rv=%b re=%b rd=%h, expected 1 0 2222222211111111", resp_valid, resp_err, readData_M);
        end
        tick;
    endtask

    task automatic test_back_to_back;
        int pulses = 0;
        int first = -1;
        int second = -1;
        memRead_M = 1'b1; memWrite_M = 1'b0; addr_M = 64'h500; req_valid = 1'b1;
        bus_ack = 1'b1; bus_rdata = 32'h5A5A5A5A;
        tick;
        addr_M = 64'h508;
        for (int c = 1; c <= 10; c++) begin
            if (resp_valid === 1'b1) begin
                pulses++;
                if (first < 0) first = c; else second = c;
            end
            if (c == 4) begin
                checks++;
                if (req_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_ready: got %b expected 1 in cycle 4", req_ready);
                end
            end
            if (c == 5) begin
                checks++;
                if (bus_req !== 1'b1 || bus_addr !== 64'h508) begin
                    errors++;
                    $display("FAIL b2b_second_accept: req=%b addr=%h, expected 1 508", bus_req, bus_addr);
                end
                req_valid = 1'b0; memRead_M = 1'b0;
            end
            tick;
        end
        bus_ack = 1'b0;
        checks++;
        if (pulses != 2 || first != 3 || second != 7) begin
            errors++;
            $display("FAIL b2b_pulses: count=%0d at %0d,%0d expected 2 at 3,7", pulses, first, second);
        end
        checks++;
        if (readData_M !== 64'h5A5A5A5A_5A5A5A5A) begin
            errors++;
            $display("FAIL b2b_data: got %h expected 5a5a5a5a5a5a5a5a", readData_M);
        end
    endtask

    initial begin
        test_reset;
        test_load_zero_wait;
        test_store_wait;
        test_accept_errors;
        test_ack_at_limit;
        test_timeout_hi;
        test_reset_mid;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
